// File: rtl/if_stage.sv
// Fetch stage: owns the fetch PC, picks sequential or redirected next-PC
// (one delay slot), and registers instruction/PC/fault into IF/ID.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        exc_adel_d,
    output logic [31:0] fetch_cnt
);
    localparam logic [31:0] PC_LAST = PC_RESET + (32'(IM_DEPTH) << 2) - 32'd4;

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic        r_exc_d;
    logic [31:0] r_cnt;
    logic        w_fault_f;

    assign w_fault_f = (r_pc_f[1:0] != 2'b00) || (r_pc_f < PC_RESET) || (r_pc_f > PC_LAST);

    // A stalled redirect is not buffered: ID re-asserts it once the stall drops.
    always_ff @(posedge clk) begin
        if (reset)
            r_pc_f <= PC_RESET;
        else if (!stall)
            r_pc_f <= redirect_valid ? redirect_target : r_pc_f + 32'd4;
    end

    // Redirect never squashes IF/ID: the delay-slot word loads normally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_d <= 32'd0;
            r_pc_d    <= PC_RESET;
            r_exc_d   <= 1'b0;
            r_cnt     <= 32'd0;
        end else if (flush) begin
            r_instr_d <= 32'd0;
            r_pc_d    <= r_pc_f;
            r_exc_d   <= 1'b0;
        end else if (!stall) begin
            r_instr_d <= w_fault_f ? 32'd0 : instr_f;
            r_pc_d    <= r_pc_f;
            r_exc_d   <= w_fault_f;
            r_cnt     <= r_cnt + 32'd1;
        end
    end

    assign pc_f       = r_pc_f;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc8_d      = r_pc_d + 32'd8;
    assign exc_adel_d = r_exc_d;
    assign fetch_cnt  = r_cnt;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic against a
// cycle-level model of the fetch/IF-ID rules.
module tb_if_stage;
    localparam logic [31:0] PCR = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, rv;
    logic [31:0] tgt, instr_f;
    logic [31:0] pc_f, instr_d, pc_d, pc8_d, fetch_cnt;
    logic        exc_adel_d;

    int errs = 0;
    int checks = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pcd, m_cnt;
    logic        m_exc;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(rv), .redirect_target(tgt), .instr_f(instr_f),
        .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
        .exc_adel_d(exc_adel_d), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign instr_f = imem(pc_f);

    function automatic logic legal(input logic [31:0] a);
        longint unsigned x;
        x = a;
        return (x % 4 == 0) && (x >= 64'h3000) && (x < 64'h3000 + 4 * 4096);
    endfunction

    // One clock: drive inputs at negedge, advance model at posedge, settle.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic v, input logic [31:0] t);
        logic [31:0] old;
        @(negedge clk);
        reset = r; stall = s; flush = f; rv = v; tgt = t;
        @(posedge clk);
        old = m_pc;
        if (r) begin
            m_pc = PCR; m_instr = 0; m_pcd = PCR; m_exc = 0; m_cnt = 0;
        end else begin
            if (f) begin
                m_instr = 0; m_pcd = old; m_exc = 0;
            end else if (!s) begin
                m_exc   = !legal(old);
                m_instr = m_exc ? 32'd0 : imem(old);
                m_pcd   = old;
                m_cnt   = m_cnt + 1;
            end
            if (!s) m_pc = v ? t : old + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0000_5000);
        checks++; if (pc_f !== 32'h3000) begin errs++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'h3000); end
        checks++; if (instr_d !== 32'h0) begin errs++; $display("FAIL reset_instr_d got=%h exp=0", instr_d); end
        checks++; if (pc_d !== 32'h3000) begin errs++; $display("FAIL reset_pc_d got=%h exp=3000", pc_d); end
        checks++; if (pc8_d !== 32'h3008) begin errs++; $display("FAIL reset_pc8_d got=%h exp=3008", pc8_d); end
        checks++; if (exc_adel_d !== 1'b0) begin errs++; $display("FAIL reset_exc got=%b exp=0", exc_adel_d); end
        checks++; if (fetch_cnt !== 32'h0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0);
            exp_pc = 32'h3000 + 32'(4 * i);
            checks++; if (pc_f !== exp_pc) begin errs++; $display("FAIL seq_pc_f got=%h exp=%h", pc_f, exp_pc); end
            checks++; if (pc_d !== exp_pc - 4) begin errs++; $display("FAIL seq_pc_d got=%h exp=%h", pc_d, exp_pc - 4); end
            checks++; if (pc8_d !== exp_pc + 4) begin errs++; $display("FAIL seq_pc8_d got=%h exp=%h", pc8_d, exp_pc + 4); end
            checks++; if (instr_d !== imem(exp_pc - 4)) begin errs++; $display("FAIL seq_instr_d got=%h exp=%h", instr_d, imem(exp_pc - 4)); end
        end
        checks++; if (fetch_cnt !== 32'd3) begin errs++; $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
    endtask

    task automatic test_redirect();
        logic [31:0] slot;
        slot = pc_f;
        step(0, 0, 0, 1, 32'h3100);
        checks++; if (pc_f !== 32'h3100) begin errs++; $display("FAIL redir_pc_f got=%h exp=3100", pc_f); end
        checks++; if (instr_d !== imem(slot) || pc_d !== slot) begin errs++; $display("FAIL redir_delay_slot got=%h/%h exp=%h/%h", instr_d, pc_d, imem(slot), slot); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc_f !== 32'h3104 || pc_d !== 32'h3100) begin errs++; $display("FAIL redir_follow got=%h/%h exp=3104/3100", pc_f, pc_d); end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] h_instr, h_pcd, h_cnt;
        step(0, 0, 0, 1, 32'h3010);
        h_instr = instr_d; h_pcd = pc_d; h_cnt = fetch_cnt;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 32'h3200);
            checks++; if (pc_f !== 32'h3010 || instr_d !== h_instr || pc_d !== h_pcd || fetch_cnt !== h_cnt) begin
                errs++; $display("FAIL stall_hold pc_f=%h instr_d=%h pc_d=%h cnt=%0d exp 3010/%h/%h/%0d",
                                 pc_f, instr_d, pc_d, fetch_cnt, h_instr, h_pcd, h_cnt);
            end
        end
        step(0, 0, 0, 1, 32'h3200);
        checks++; if (pc_f !== 32'h3200) begin errs++; $display("FAIL stall_release_pc got=%h exp=3200", pc_f); end
        checks++; if (instr_d !== imem(32'h3010) || fetch_cnt !== h_cnt + 1) begin errs++; $display("FAIL stall_release_load got=%h cnt=%0d exp=%h cnt=%0d", instr_d, fetch_cnt, imem(32'h3010), h_cnt + 1); end
    endtask

    task automatic test_fault();
        step(0, 0, 0, 1, 32'h3102);
        step(0, 0, 0, 0, 0);
        checks++; if (exc_adel_d !== 1'b1 || instr_d !== 0 || pc_d !== 32'h3102) begin errs++; $display("FAIL fault_misalign exc=%b instr=%h pc_d=%h exp 1/0/3102", exc_adel_d, instr_d, pc_d); end
        checks++; if (pc_f !== 32'h3106) begin errs++; $display("FAIL fault_advance got=%h exp=3106", pc_f); end
        step(0, 0, 0, 1, 32'h2FFC);
        step(0, 0, 0, 0, 0);
        checks++; if (exc_adel_d !== 1'b1 || instr_d !== 0 || pc_d !== 32'h2FFC) begin errs++; $display("FAIL fault_low exc=%b instr=%h pc_d=%h exp 1/0/2ffc", exc_adel_d, instr_d, pc_d); end
        checks++; if (pc_f !== 32'h3000) begin errs++; $display("FAIL fault_low_next got=%h exp=3000", pc_f); end
        step(0, 0, 0, 1, 32'h6FFC);
        step(0, 0, 0, 0, 0);
        checks++; if (exc_adel_d !== 1'b0 || instr_d !== imem(32'h6FFC)) begin errs++; $display("FAIL fault_top_legal exc=%b instr=%h exp 0/%h", exc_adel_d, instr_d, imem(32'h6FFC)); end
        checks++; if (pc_f !== 32'h7000) begin errs++; $display("FAIL fault_top_pc got=%h exp=7000", pc_f); end
        step(0, 0, 0, 0, 0);
        checks++; if (exc_adel_d !== 1'b1 || instr_d !== 0) begin errs++; $display("FAIL fault_top_over exc=%b instr=%h exp 1/0", exc_adel_d, instr_d); end
        step(0, 0, 0, 1, 32'h3020);
    endtask

    task automatic test_flush_stall();
        logic [31:0] h_pc, h_cnt;
        step(0, 0, 0, 0, 0);
        h_pc = pc_f; h_cnt = fetch_cnt;
        step(0, 1, 1, 0, 0);
        checks++; if (instr_d !== 0 || exc_adel_d !== 0 || pc_d !== h_pc) begin errs++; $display("FAIL flush_stall_ifid instr=%h exc=%b pc_d=%h exp 0/0/%h", instr_d, exc_adel_d, pc_d, h_pc); end
        checks++; if (pc_f !== h_pc || fetch_cnt !== h_cnt) begin errs++; $display("FAIL flush_stall_hold pc_f=%h cnt=%0d exp %h/%0d", pc_f, fetch_cnt, h_pc, h_cnt); end
        step(0, 0, 1, 0, 0);
        checks++; if (instr_d !== 0 || pc_f !== h_pc + 4 || fetch_cnt !== h_cnt) begin errs++; $display("FAIL flush_only instr=%h pc_f=%h cnt=%0d exp 0/%h/%0d", instr_d, pc_f, fetch_cnt, h_pc + 4, h_cnt); end
    endtask

    task automatic test_random();
        logic r, s, f, v;
        logic [31:0] t;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            v = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0:       t = $urandom;
                1:       t = 32'h3000 + {$urandom_range(0, 4095), 2'b00} + 32'($urandom_range(0, 1) * 2);
                default: t = 32'h3000 + {$urandom_range(0, 4095), 2'b00};
            endcase
            step(r, s, f, v, t);
            checks++;
            if (pc_f !== m_pc || instr_d !== m_instr || pc_d !== m_pcd || pc8_d !== m_pcd + 8 ||
                exc_adel_d !== m_exc || fetch_cnt !== m_cnt) begin
                errs++;
                $display("FAIL random[%0d] got pc_f=%h instr=%h pc_d=%h pc8=%h exc=%b cnt=%0d exp %h/%h/%h/%h/%b/%0d",
                         i, pc_f, instr_d, pc_d, pc8_d, exc_adel_d, fetch_cnt,
                         m_pc, m_instr, m_pcd, m_pcd + 8, m_exc, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1, 32'h3040);
        step(0, 0, 0, 0, 0);
        checks++; if (pc_f !== 32'h3044 || fetch_cnt === 0) begin errs++; $display("FAIL mid_setup pc_f=%h cnt=%0d exp 3044/nonzero", pc_f, fetch_cnt); end
        step(0, 0, 0, 1, 32'h3040);
        step(1, 0, 0, 1, 32'h3500);
        checks++; if (pc_f !== 32'h3000 || instr_d !== 0 || fetch_cnt !== 0 || pc_d !== 32'h3000 || exc_adel_d !== 0) begin
            errs++; $display("FAIL mid_reset pc_f=%h instr=%h cnt=%0d pc_d=%h exc=%b exp 3000/0/0/3000/0", pc_f, instr_d, fetch_cnt, pc_d, exc_adel_d);
        end
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; rv = 0; tgt = 0;
        m_pc = PCR; m_instr = 0; m_pcd = PCR; m_exc = 0; m_cnt = 0;
        test_reset();
        test_seq();
        test_redirect();
        test_stall_redirect();
        test_fault();
        test_flush_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
